// File: rtl/usb_host_xact_pkg.sv
// rtl/usb_host_xact_pkg.sv - USB PID codes, host turnaround limit and FSM state type
package usb_host_xact_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;
    localparam logic [3:0] PID_ERR   = 4'b1100;

    // 816 bit-times of high-speed turnaround at the 60 MHz ULPI clock
    localparam logic [6:0] USB_HS_TIMEOUT = 7'd102;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKN,
        ST_DATA,
        ST_HSKW,
        ST_RECV,
        ST_RACK
    } xact_state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic is_hsk_pid(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL) || (pid == PID_NYET);
    endfunction

endpackage

// File: rtl/usb_host_xact_toggle_table.sv
// rtl/usb_host_xact_toggle_table.sv - per-endpoint IN/OUT DATA0/DATA1 toggle store
module usb_toggle_table
    import usb_host_xact_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       set_pair,
    input  logic       flip_en,
    input  logic       flip_in,
    input  logic [3:0] endp,
    output logic       out_tog,
    output logic       in_tog
);

    // bit {dir, endp}: dir 0 = OUT, 1 = IN
    logic [31:0] tog;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tog <= '0;
        end else if (clr) begin
            tog <= '0;
        end else if (set_pair) begin
            tog[{1'b0, endp}] <= 1'b1;
            tog[{1'b1, endp}] <= 1'b1;
        end else if (flip_en) begin
            tog[{flip_in, endp}] <= ~tog[{flip_in, endp}];
        end
    end

    assign out_tog = tog[{1'b0, endp}];
    assign in_tog  = tog[{1'b1, endp}];

endmodule

// File: rtl/usb_host_xact.sv
// rtl/usb_host_xact.sv - host-side USB 2.0 HS transaction sequencer (token, data, handshake)
module usb_host_xact
    import usb_host_xact_pkg::*;
#(
    parameter logic [6:0] TIMEOUT = USB_HS_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] usb_addr_i,
    input  logic       clr_tog_i,
    input  logic       xfer_req_i,
    input  logic [3:0] xfer_pid_i,
    input  logic [3:0] xfer_endp_i,
    output logic       xfer_ack_o,
    output logic       done_o,
    output logic [3:0] result_o,
    output logic       rx_ok_o,
    output logic       rx_drop_o,
    output logic       tok_send_o,
    output logic [3:0] tok_pid_o,
    output logic [6:0] tok_addr_o,
    output logic [3:0] tok_endp_o,
    input  logic       tok_sent_i,
    output logic       dat_send_o,
    output logic [3:0] dat_pid_o,
    input  logic       usb_sent_i,
    output logic       hsk_send_o,
    output logic [3:0] hsk_pid_o,
    input  logic       hsk_sent_i,
    input  logic       hsk_recv_i,
    input  logic       usb_recv_i,
    input  logic       eop_recv_i,
    input  logic       crc_error_i,
    input  logic [3:0] usb_pid_i
);

    xact_state_t state;
    logic [6:0]  timer;
    logic        got_data;
    logic        rx_seq;
    logic        out_tog, in_tog;

    logic        fin;
    logic [3:0]  fin_res;
    logic        rx_done, rx_match;
    logic        tog_set, tog_flip, tog_flip_in;

    usb_toggle_table u_toggle (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr_tog_i),
        .set_pair (tog_set),
        .flip_en  (tog_flip),
        .flip_in  (tog_flip_in),
        .endp     (tok_endp_o),
        .out_tog  (out_tog),
        .in_tog   (in_tog)
    );

    // Decode the cycle's terminating event and toggle side effects.
    always_comb begin
        fin         = 1'b0;
        fin_res     = PID_ERR;
        rx_done     = 1'b0;
        rx_match    = (rx_seq == in_tog);
        tog_set     = 1'b0;
        tog_flip    = 1'b0;
        tog_flip_in = 1'b0;
        if (state != ST_IDLE && timer == 7'd0) begin
            fin = 1'b1;
        end else begin
            case (state)
                ST_HSKW: begin
                    if (hsk_recv_i) begin
                        fin = 1'b1;
                        if (is_hsk_pid(usb_pid_i)) begin
                            fin_res = usb_pid_i;
                            if (tok_pid_o == PID_OUT &&
                                (usb_pid_i == PID_ACK || usb_pid_i == PID_NYET))
                                tog_flip = 1'b1;
                            if (tok_pid_o == PID_SETUP && usb_pid_i == PID_ACK)
                                tog_set = 1'b1;
                        end
                    end else if (usb_recv_i) begin
                        fin = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (crc_error_i) begin
                        fin = 1'b1;
                    end else if (hsk_recv_i) begin
                        fin = 1'b1;
                        if (usb_pid_i == PID_NAK || usb_pid_i == PID_STALL)
                            fin_res = usb_pid_i;
                    end else if (usb_recv_i) begin
                        fin = !is_data_pid(usb_pid_i);
                    end else if (eop_recv_i && got_data) begin
                        rx_done     = 1'b1;
                        tog_flip    = rx_match;
                        tog_flip_in = 1'b1;
                    end
                end
                ST_RACK: begin
                    if (hsk_sent_i) begin
                        fin     = 1'b1;
                        fin_res = PID_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            got_data   <= 1'b0;
            rx_seq     <= 1'b0;
            xfer_ack_o <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            rx_ok_o    <= 1'b0;
            rx_drop_o  <= 1'b0;
            tok_send_o <= 1'b0;
            tok_pid_o  <= '0;
            tok_addr_o <= '0;
            tok_endp_o <= '0;
            dat_send_o <= 1'b0;
            dat_pid_o  <= '0;
            hsk_send_o <= 1'b0;
            hsk_pid_o  <= '0;
        end else begin
            xfer_ack_o <= 1'b0;
            done_o     <= 1'b0;
            rx_ok_o    <= 1'b0;
            rx_drop_o  <= 1'b0;
            if (state != ST_IDLE)
                timer <= timer - 7'd1;
            if (state == ST_IDLE) begin
                if (xfer_req_i) begin
                    xfer_ack_o <= 1'b1;
                    tok_send_o <= 1'b1;
                    tok_pid_o  <= xfer_pid_i;
                    tok_endp_o <= xfer_endp_i;
                    tok_addr_o <= usb_addr_i;
                    got_data   <= 1'b0;
                    timer      <= TIMEOUT;
                    state      <= ST_TOKN;
                end
            end else if (fin) begin
                done_o     <= 1'b1;
                result_o   <= fin_res;
                tok_send_o <= 1'b0;
                dat_send_o <= 1'b0;
                hsk_send_o <= 1'b0;
                state      <= ST_IDLE;
            end else begin
                case (state)
                    ST_TOKN: begin
                        if (tok_sent_i) begin
                            tok_send_o <= 1'b0;
                            timer      <= TIMEOUT;
                            if (tok_pid_o == PID_IN) begin
                                state <= ST_RECV;
                            end else if (tok_pid_o == PID_PING) begin
                                state <= ST_HSKW;
                            end else begin
                                dat_send_o <= 1'b1;
                                dat_pid_o  <= (tok_pid_o == PID_SETUP || !out_tog) ?
                                              PID_DATA0 : PID_DATA1;
                                state      <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (usb_sent_i) begin
                            dat_send_o <= 1'b0;
                            timer      <= TIMEOUT;
                            state      <= ST_HSKW;
                        end
                    end
                    ST_RECV: begin
                        if (usb_recv_i) begin
                            got_data <= 1'b1;
                            rx_seq   <= usb_pid_i[3];
                        end else if (rx_done) begin
                            rx_ok_o    <= rx_match;
                            rx_drop_o  <= !rx_match;
                            hsk_send_o <= 1'b1;
                            hsk_pid_o  <= PID_ACK;
                            timer      <= TIMEOUT;
                            state      <= ST_RACK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
